// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: widths, PC-1/PC-2 selection tables,
// the per-round shift schedule and the engine's state encoding.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 56;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Entries are 1-based DES bit numbers, bit 1 being the MSB of the source word.
  localparam int PC1_TBL [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Shift table s1..s16 = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; bit n-1 set when s[n] == 2.
  localparam logic [15:0] SHIFT_IS2 = 16'b0111_1110_1111_1100;

  function automatic logic [1:0] shift_amt(input logic [3:0] n_minus1);
    return SHIFT_IS2[n_minus1] ? 2'd2 : 2'd1;
  endfunction

  // dir: 0 = rotate left, 1 = rotate right; amt is 1 or 2.
  function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] x,
                                              input logic dir,
                                              input logic [1:0] amt);
    logic [HALF_W-1:0] r;
    case ({dir, amt == 2'd2})
      2'b00:   r = {x[26:0], x[27]};
      2'b01:   r = {x[25:0], x[27:26]};
      2'b10:   r = {x[0], x[27:1]};
      default: r = {x[1:0], x[27:2]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_schedule_if.sv
// Key-in / subkey-out handshake bundle between the key source, the
// schedule engine and the round controller.
interface key_schedule_if;
  logic [des_pkg::KEY_W-1:0]    key;
  logic                         dec;
  logic                         key_valid;
  logic                         key_ready;
  logic [des_pkg::SUBKEY_W-1:0] k;
  logic [3:0]                   k_idx;
  logic                         k_valid;
  logic                         k_ready;

  modport master (
    output key, dec, key_valid, k_ready,
    input  key_ready, k, k_idx, k_valid
  );

  modport slave (
    input  key, dec, key_valid, k_ready,
    output key_ready, k, k_idx, k_valid
  );
endinterface

// File: rtl/key_schedule_key_rot.sv
// Rotates the C and D halves of the CD register independently by 1 or 2
// positions, left for encrypt order and right for decrypt order.
module key_rot
  import des_pkg::*;
(
  input  logic [CD_W-1:0] cd,
  input  logic            dir,
  input  logic [1:0]      amt,
  output logic [CD_W-1:0] cd_rot
);
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_half
    assign cd_rot[gi*HALF_W +: HALF_W] = rot28(cd[gi*HALF_W +: HALF_W], dir, amt);
  end
endmodule

// File: rtl/key_schedule_perm.sv
// Fixed DES bit-selection networks PC-1 (key -> CD) and PC-2 (CD -> subkey),
// pure wiring built from the package tables.
module perm_PC1
  import des_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  output logic [CD_W-1:0]  cd
);
  genvar gi;
  for (gi = 0; gi < CD_W; gi++) begin : g_bit
    assign cd[CD_W-1-gi] = key[KEY_W-PC1_TBL[gi]];
  end

  // Parity bits (DES bits 8,16,...,64) never reach the schedule.
  logic parity_unused;
  assign parity_unused = ^{key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8], key[0]};
endmodule

module perm_PC2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] k
);
  genvar gi;
  for (gi = 0; gi < SUBKEY_W; gi++) begin : g_bit
    assign k[SUBKEY_W-1-gi] = cd[CD_W-PC2_TBL[gi]];
  end

  // CD bits 9,18,22,25,35,38,43,54 are dropped by PC-2.
  logic dropped_unused;
  assign dropped_unused = ^{cd[47], cd[38], cd[34], cd[31],
                            cd[21], cd[18], cd[13], cd[2]};
endmodule

// File: rtl/key_schedule.sv
// DES key-schedule engine: takes one key, then streams the 16 round subkeys
// in encrypt (K1..K16) or decrypt (K16..K1) order under valid/ready.
module key_schedule
  import des_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  key_schedule_if.slave bus
);
  state_t              state_reg, state_next;
  logic [CD_W-1:0]     cd_reg, cd_next;
  logic [3:0]          k_idx_reg, k_idx_next;
  logic                dec_q_reg, dec_q_next;

  logic [CD_W-1:0]     pc1_key;
  logic [CD_W-1:0]     rot_in, rot_out;
  logic                rot_dir;
  logic [1:0]          rot_amt;

  perm_PC1 u_pc1 (.key(bus.key), .cd(pc1_key));

  // One rotator serves both the load step (rotl by s1) and the per-transfer
  // step; decrypt walks backwards from C16D16 = PC1(key), indexing s[16-k_idx].
  always_comb begin
    rot_in  = cd_reg;
    rot_dir = dec_q_reg;
    rot_amt = dec_q_reg ? shift_amt(~k_idx_reg) : shift_amt(k_idx_reg + 4'd1);
    if (state_reg == ST_IDLE) begin
      rot_in  = pc1_key;
      rot_dir = 1'b0;
      rot_amt = shift_amt(4'd0);
    end
  end

  key_rot u_rot (
    .cd     (rot_in),
    .dir    (rot_dir),
    .amt    (rot_amt),
    .cd_rot (rot_out)
  );

  perm_PC2 u_pc2 (.cd(cd_reg), .k(bus.k));

  assign bus.k_idx = k_idx_reg;

  always_comb begin
    state_next    = state_reg;
    cd_next       = cd_reg;
    k_idx_next    = k_idx_reg;
    dec_q_next    = dec_q_reg;
    bus.key_ready = 1'b0;
    bus.k_valid   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bus.key_ready = 1'b1;
        if (bus.key_valid) begin
          state_next = ST_RUN;
          dec_q_next = bus.dec;
          k_idx_next = 4'd0;
          cd_next    = bus.dec ? pc1_key : rot_out;
        end
      end
      ST_RUN: begin
        bus.k_valid = 1'b1;
        if (bus.k_ready) begin
          if (k_idx_reg == 4'd15) begin
            state_next = ST_IDLE;
            k_idx_next = 4'd0;
          end else begin
            k_idx_next = k_idx_reg + 4'd1;
            cd_next    = rot_out;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cd_reg    <= '0;
      k_idx_reg <= 4'd0;
      dec_q_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cd_reg    <= cd_next;
      k_idx_reg <= k_idx_next;
      dec_q_reg <= dec_q_next;
    end
  end
endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: subkeys are predicted from the DES
// definition (PC-1, cumulative half rotations, PC-2) and known-answer vectors.
module tb_key_schedule;
  logic clk = 1'b0;
  logic rst = 1'b0;
  key_schedule_if bus ();

  key_schedule dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] K_EX  = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_EX = 48'h1B02EFFC7072;
  localparam logic [47:0] K2_EX = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16_EX = 48'hCB3D8B0E17F5;

  int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int shift_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Round subkey K(r): both halves of PC1(key) rotated left by s1+..+sr, then PC-2.
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int r);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk;
    int tot;
    tot = 0;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
    for (int i = 0; i < r; i++) tot += shift_t[i];
    c = cd[55:28];
    d = cd[27:0];
    c = (c << tot) | (c >> (28 - tot));
    d = (d << tot) | (d >> (28 - tot));
    cd = {c, d};
    for (int i = 0; i < 48; i++) sk[47-i] = cd[56-pc2_t[i]];
    return sk;
  endfunction

  function automatic logic [47:0] ref_at(input logic [63:0] key, input logic dec, input int idx);
    return dec ? ref_subkey(key, 16 - idx) : ref_subkey(key, idx + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] nk;
    #1;
    checks += 4;
    if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b expected 1", bus.key_ready); end
    if (bus.k_valid !== 1'b0) begin errors++; $display("FAIL reset_k_valid: got %b expected 0", bus.k_valid); end
    if (bus.k_idx !== 4'd0) begin errors++; $display("FAIL reset_k_idx: got %0d expected 0", bus.k_idx); end
    if (bus.k !== 48'h0) begin errors++; $display("FAIL reset_k: got %h expected 0", bus.k); end
    tick();
    rst = 1'b1;
    tick();
    bus.key = K_EX; bus.dec = 1'b0; bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    repeat (7) tick();
    checks++;
    if (bus.k_idx !== 4'd7) begin errors++; $display("FAIL reset_pre_idx: got %0d expected 7", bus.k_idx); end
    rst = 1'b0;
    #1;
    checks += 4;
    if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL async_key_ready: got %b expected 1", bus.key_ready); end
    if (bus.k_valid !== 1'b0) begin errors++; $display("FAIL async_k_valid: got %b expected 0", bus.k_valid); end
    if (bus.k_idx !== 4'd0) begin errors++; $display("FAIL async_k_idx: got %0d expected 0", bus.k_idx); end
    if (bus.k !== 48'h0) begin errors++; $display("FAIL async_k: got %h expected 0", bus.k); end
    tick();
    rst = 1'b1;
    tick();
    nk = {$urandom, $urandom};
    bus.key = nk; bus.dec = 1'b1; bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    checks += 2;
    if (bus.k_valid !== 1'b1 || bus.k_idx !== 4'd0) begin
      errors++; $display("FAIL post_reset_accept: got valid=%b idx=%0d expected valid=1 idx=0", bus.k_valid, bus.k_idx);
    end
    if (bus.k !== ref_at(nk, 1'b1, 0)) begin
      errors++; $display("FAIL post_reset_k: got %h expected %h", bus.k, ref_at(nk, 1'b1, 0));
    end
    repeat (16) tick();
    $display("reset: key=%h aborted at idx 7, reload dec=1 done", nk);
  endtask

  task automatic test_mode(input logic dec);
    bus.key = K_EX; bus.dec = dec; bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks += 2;
      if (bus.k_valid !== 1'b1 || bus.k_idx !== i[3:0]) begin
        errors++; $display("FAIL mode%0d_idx: got valid=%b idx=%0d expected valid=1 idx=%0d", dec, bus.k_valid, bus.k_idx, i);
      end
      if (bus.k !== ref_at(K_EX, dec, i)) begin
        errors++; $display("FAIL mode%0d_k[%0d]: got %h expected %h", dec, i, bus.k, ref_at(K_EX, dec, i));
      end
      if ((!dec && i == 0) || (dec && i == 15)) begin
        checks++;
        if (bus.k !== K1_EX) begin errors++; $display("FAIL kat_K1: got %h expected %h", bus.k, K1_EX); end
      end
      if (!dec && i == 1) begin
        checks++;
        if (bus.k !== K2_EX) begin errors++; $display("FAIL kat_K2: got %h expected %h", bus.k, K2_EX); end
      end
      if ((!dec && i == 15) || (dec && i == 0)) begin
        checks++;
        if (bus.k !== K16_EX) begin errors++; $display("FAIL kat_K16: got %h expected %h", bus.k, K16_EX); end
      end
      tick();
    end
    checks++;
    if (bus.key_ready !== 1'b1 || bus.k_valid !== 1'b0) begin
      errors++; $display("FAIL mode%0d_end: got ready=%b valid=%b expected ready=1 valid=0", dec, bus.key_ready, bus.k_valid);
    end
    $display("mode dec=%0d: key=%h 16 subkeys streamed", dec, K_EX);
  endtask

  task automatic test_encrypt();
    test_mode(1'b0);
  endtask

  task automatic test_decrypt();
    test_mode(1'b1);
  endtask

  task automatic test_backpressure();
    logic [63:0] bk;
    bk = {$urandom, $urandom};
    bus.key = bk; bus.dec = 1'b0; bus.key_valid = 1'b1; bus.k_ready = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    repeat (3) tick();
    bus.k_ready = 1'b0;
    bus.key = ~bk; bus.dec = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.key_valid = c[0];
      tick();
      checks += 2;
      if (bus.k !== ref_at(bk, 1'b0, 3) || bus.k_idx !== 4'd3) begin
        errors++; $display("FAIL stall_hold: got k=%h idx=%0d expected k=%h idx=3", bus.k, bus.k_idx, ref_at(bk, 1'b0, 3));
      end
      if (bus.k_valid !== 1'b1 || bus.key_ready !== 1'b0) begin
        errors++; $display("FAIL stall_flags: got valid=%b ready=%b expected valid=1 ready=0", bus.k_valid, bus.key_ready);
      end
    end
    bus.key_valid = 1'b0;
    bus.k_ready = 1'b1;
    for (int i = 3; i < 16; i++) begin
      checks++;
      if (bus.k !== ref_at(bk, 1'b0, i) || bus.k_idx !== i[3:0]) begin
        errors++; $display("FAIL resume_k[%0d]: got k=%h idx=%0d expected k=%h", i, bus.k, bus.k_idx, ref_at(bk, 1'b0, i));
      end
      tick();
    end
    $display("backpressure: key=%h stalled 5 cycles at idx 3", bk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] ka, kb;
    logic da, db;
    ka = {$urandom, $urandom}; kb = {$urandom, $urandom};
    da = 1'($urandom_range(0, 1)); db = ~da;
    bus.key = ka; bus.dec = da; bus.key_valid = 1'b1; bus.k_ready = 1'b1;
    tick();
    bus.key = kb; bus.dec = db;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.k_valid !== 1'b1 || bus.k !== ref_at(ka, da, i) || bus.k_idx !== i[3:0]) begin
        errors++; $display("FAIL b2b_a[%0d]: got v=%b k=%h idx=%0d expected k=%h", i, bus.k_valid, bus.k, bus.k_idx, ref_at(ka, da, i));
      end
      tick();
    end
    checks++;
    if (bus.key_ready !== 1'b1 || bus.k_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: got ready=%b valid=%b expected ready=1 valid=0", bus.key_ready, bus.k_valid);
    end
    tick();
    bus.key_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.k_valid !== 1'b1 || bus.k !== ref_at(kb, db, i) || bus.k_idx !== i[3:0]) begin
        errors++; $display("FAIL b2b_b[%0d]: got v=%b k=%h idx=%0d expected k=%h", i, bus.k_valid, bus.k, bus.k_idx, ref_at(kb, db, i));
      end
      tick();
    end
    checks++;
    if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL b2b_end: got ready=%b expected 1", bus.key_ready); end
    $display("back_to_back: keys %h/%h in 34 cycles", ka, kb);
  endtask

  task automatic test_boundary();
    logic [63:0] bkey;
    logic [47:0] exp;
    for (int m = 0; m < 4; m++) begin
      bkey = (m >= 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
      exp  = (m >= 2) ? 48'hFFFF_FFFF_FFFF : 48'h0;
      bus.key = bkey; bus.dec = m[0]; bus.key_valid = 1'b1;
      tick();
      bus.key_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (bus.k !== exp || bus.k_valid !== 1'b1) begin
          errors++; $display("FAIL boundary_k[%0d] key=%h: got %h expected %h", i, bkey, bus.k, exp);
        end
        tick();
      end
      $display("boundary: key=%h dec=%0d", bkey, m[0]);
    end
  endtask

  task automatic test_random();
    logic [63:0] rk;
    logic rd;
    int idx, cyc;
    for (int n = 0; n < 8; n++) begin
      rk = {$urandom, $urandom};
      rd = 1'($urandom_range(0, 1));
      bus.key = rk; bus.dec = rd; bus.key_valid = 1'b1; bus.k_ready = 1'b1;
      tick();
      bus.key_valid = 1'b0;
      idx = 0; cyc = 0;
      while (idx < 16 && cyc < 300) begin
        bus.k_ready = ($urandom_range(0, 3) != 0);
        checks++;
        if (bus.k_valid !== 1'b1 || bus.k_idx !== idx[3:0] || bus.k !== ref_at(rk, rd, idx)) begin
          errors++; $display("FAIL rand_k[%0d]: got v=%b idx=%0d k=%h expected k=%h", idx, bus.k_valid, bus.k_idx, bus.k, ref_at(rk, rd, idx));
        end
        tick();
        if (bus.k_ready) idx++;
        cyc++;
      end
      checks++;
      if (idx != 16 || bus.key_ready !== 1'b1) begin
        errors++; $display("FAIL rand_done: got idx=%0d ready=%b expected 16 and 1", idx, bus.key_ready);
      end
      bus.k_ready = 1'b1;
      $display("random: key=%h dec=%0d done in %0d cycles", rk, rd, cyc);
    end
  endtask

  initial begin
    bus.key = '0; bus.dec = 1'b0; bus.key_valid = 1'b0; bus.k_ready = 1'b1;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_back_to_back();
    test_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
